// File: rtl/module_teclado_tx.sv
// Keypad emulator: replays a BCD number as timed Gray-coded key presses, MS digit first.
// Optional nibble range check (adds err output) enabled by defining TECLADO_TX_BCD_CHECK_EN.
module module_teclado_tx #(
  parameter int unsigned DIGITS      = 3,
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned GAP_CYCLES  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   num_in,
  output logic                  ag,
  output logic                  bg,
  output logic                  cg,
  output logic                  dg,
  output logic                  key_valid,
  output logic                  busy,
  output logic                  done
`ifdef TECLADO_TX_BCD_CHECK_EN
  ,
  output logic                  err
`endif
);

  localparam int unsigned NUM_W     = 4 * DIGITS;
  localparam int unsigned PHASE_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int unsigned CNT_W     = (PHASE_MAX > 1) ? $clog2(PHASE_MAX) : 1;
  localparam int unsigned DIG_W     = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HOLD = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DIG_W-1:0] dig_q, dig_d;
  logic [NUM_W-1:0] sr_q, sr_d;

  function automatic logic [3:0] gray4(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

`ifdef TECLADO_TX_BCD_CHECK_EN
  logic bad_q, bad_d;

  function automatic logic has_bad(input logic [NUM_W-1:0] v);
    logic b;
    b = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) b = 1'b1;
    end
    return b;
  endfunction
`endif

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      dig_q   <= '0;
      sr_q    <= '0;
`ifdef TECLADO_TX_BCD_CHECK_EN
      bad_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dig_q   <= dig_d;
      sr_q    <= sr_d;
`ifdef TECLADO_TX_BCD_CHECK_EN
      bad_q   <= bad_d;
`endif
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dig_d   = dig_q;
    sr_d    = sr_q;
`ifdef TECLADO_TX_BCD_CHECK_EN
    bad_d   = bad_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          sr_d    = num_in;
          dig_d   = DIG_W'(DIGITS - 1);
          cnt_d   = '0;
          state_d = ST_HOLD;
`ifdef TECLADO_TX_BCD_CHECK_EN
          bad_d   = has_bad(num_in);
          if (has_bad(num_in)) state_d = ST_DONE;
`endif
        end
      end
      ST_HOLD: begin
        if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = ST_GAP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_GAP: begin
        if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
          cnt_d = '0;
          if (dig_q == '0) begin
            state_d = ST_DONE;
          end else begin
            dig_d   = dig_q - DIG_W'(1);
            sr_d    = sr_q << 4;
            state_d = ST_HOLD;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Registered outputs decoded from the current state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      {ag, bg, cg, dg} <= 4'b0000;
      key_valid        <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
`ifdef TECLADO_TX_BCD_CHECK_EN
      err              <= 1'b0;
`endif
    end else begin
      {ag, bg, cg, dg} <= (state_q == ST_HOLD) ? gray4(sr_q[NUM_W-1 -: 4]) : 4'b0000;
      key_valid        <= (state_q == ST_HOLD);
      busy             <= (state_q == ST_HOLD) || (state_q == ST_GAP);
      done             <= (state_q == ST_DONE);
`ifdef TECLADO_TX_BCD_CHECK_EN
      if ((state_q == ST_DONE) && bad_q) err <= 1'b1;
      else if (state_q == ST_HOLD)       err <= 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_module_teclado_tx.sv
// Self-checking bench for module_teclado_tx against a timeline model of the key sequence.
module tb_module_teclado_tx;

  localparam int D = 3;
  localparam int H = 4;
  localparam int G = 2;
  localparam int TAB = 256;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [11:0] num_in;
  logic        ag, bg, cg, dg, key_valid, busy, done;
`ifdef TECLADO_TX_BCD_CHECK_EN
  logic        err;
`endif

  module_teclado_tx #(.DIGITS(D), .HOLD_CYCLES(H), .GAP_CYCLES(G)) dut (
    .clk(clk), .rst(rst), .start(start), .num_in(num_in),
    .ag(ag), .bg(bg), .cg(cg), .dg(dg),
    .key_valid(key_valid), .busy(busy), .done(done)
`ifdef TECLADO_TX_BCD_CHECK_EN
    , .err(err)
`endif
  );

  always #5 clk = ~clk;

  // expected {code[3:0], key_valid, busy, done} per edge; err events: 1 set, 2 clear
  logic [6:0] exp_tab [TAB];
  int         err_evt [TAB];
  int         edge_n = 0;
  int         free_edge = 0;
  logic       err_model = 1'b0;
  int         checks = 0;
  int         failures = 0;
  int         done_cnt = 0;

  function automatic void clear_model();
    for (int i = 0; i < TAB; i++) begin
      exp_tab[i] = 7'b0;
      err_evt[i] = 0;
    end
    free_edge = 0;
    err_model = 1'b0;
  endfunction

  function automatic void accept(int t, logic [11:0] v);
    logic [3:0] dig, code;
    int base;
    bit bad;
    bad = 0;
    for (int i = 0; i < D; i++) if (v[4*i +: 4] > 4'd9) bad = 1;
`ifdef TECLADO_TX_BCD_CHECK_EN
    if (bad) begin
      exp_tab[(t+1)%TAB] = 7'b0000_001;
      err_evt[(t+1)%TAB] = 1;
      free_edge = t + 2;
      return;
    end
    err_evt[(t+1)%TAB] = 2;
`endif
    for (int d = 0; d < D; d++) begin
      dig  = v[4*(D-1-d) +: 4];
      code = dig ^ (dig >> 1);
      base = t + 1 + d*(H+G);
      for (int h = 0; h < H; h++) exp_tab[(base+h)%TAB] = {code, 3'b110};
      for (int g = 0; g < G; g++) exp_tab[(base+H+g)%TAB] = 7'b0000_010;
    end
    exp_tab[(t+1+D*(H+G))%TAB] = 7'b0000_001;
    free_edge = t + 2 + D*(H+G);
    if (bad) err_model = err_model; // out-of-range digits are sent unchecked
  endfunction

  function automatic logic [6:0] obs();
    return {ag, bg, cg, dg, key_valid, busy, done};
  endfunction

  task automatic check_now(string tag, logic [6:0] expv);
    checks++;
    assert (obs() === expv) else begin
      failures++;
      $error("FAIL %s edge=%0d observed=%b expected=%b", tag, edge_n, obs(), expv);
    end
`ifdef TECLADO_TX_BCD_CHECK_EN
    checks++;
    assert (err === err_model) else begin
      failures++;
      $error("FAIL %s_err edge=%0d observed=%b expected=%b", tag, edge_n, err, err_model);
    end
`endif
  endtask

  task automatic step(string tag);
    @(posedge clk);
    edge_n++;
    if (rst === 1'b1 && start === 1'b1 && edge_n >= free_edge) accept(edge_n, num_in);
    #1;
    if (err_evt[edge_n%TAB] == 1) err_model = 1'b1;
    if (err_evt[edge_n%TAB] == 2) err_model = 1'b0;
    check_now(tag, exp_tab[edge_n%TAB]);
    if (done === 1'b1) done_cnt++;
    exp_tab[edge_n%TAB] = 7'b0;
    err_evt[edge_n%TAB] = 0;
  endtask

  task automatic steps(int n, string tag);
    for (int i = 0; i < n; i++) step(tag);
  endtask

  task automatic async_reset(string tag);
    #2 rst = 1'b0;
    #1;
    clear_model();
    check_now(tag, 7'b0);
  endtask

  initial begin
    clear_model();
    rst = 1'b0;
    start = 1'b1;
    num_in = 12'h347;
    #1 check_now("reset_init", 7'b0);
    steps(3, "reset_hold");
    rst = 1'b1;
    start = 1'b0;
    steps(3, "reset_release");

    // single transfer of 347
    start = 1'b1;
    step("t347_accept");
    start = 1'b0;
    num_in = 12'h000;
    steps(22, "t347");

    // start held high: back-to-back transfers of 905
    num_in = 12'h905;
    start = 1'b1;
    steps(40, "t905_held");
    start = 1'b0;
    steps(5, "t905_tail");

    // start during busy is ignored
    num_in = 12'h111;
    start = 1'b1;
    step("t111_accept");
    start = 1'b0;
    steps(5, "t111");
    done_cnt = 0;
    num_in = 12'h999;
    start = 1'b1;
    step("t111_ignored");
    start = 1'b0;
    steps(20, "t111");
    checks++;
    assert (done_cnt == 1) else begin
      failures++;
      $error("FAIL t111_done_count observed=%0d expected=1", done_cnt);
    end

    // reset in the middle of a transfer
    num_in = 12'h555;
    start = 1'b1;
    step("t555_accept");
    start = 1'b0;
    steps(7, "t555");
    done_cnt = 0;
    async_reset("t555_async_rst");
    steps(2, "t555_in_rst");
    rst = 1'b1;
    steps(2, "t555_released");
    checks++;
    assert (done_cnt == 0) else begin
      failures++;
      $error("FAIL t555_no_done observed=%0d expected=0", done_cnt);
    end
    start = 1'b1;
    step("t555_restart");
    start = 1'b0;
    steps(21, "t555_clean");

`ifdef TECLADO_TX_BCD_CHECK_EN
    num_in = 12'h3A2;
    start = 1'b1;
    step("bad_accept");
    start = 1'b0;
    steps(3, "bad");
    num_in = 12'h123;
    start = 1'b1;
    step("t123_accept");
    start = 1'b0;
    steps(21, "t123");
`endif

    // randomized starts with random numbers and background num_in churn
    for (int i = 0; i < 400; i++) begin
      start = ($urandom_range(0, 3) == 0);
      num_in = 12'($urandom);
      if ($urandom_range(0, 7) != 0) begin
        for (int k = 0; k < D; k++) num_in[4*k +: 4] = 4'($urandom_range(0, 9));
      end
      step("random");
    end
    start = 1'b0;
    steps(22, "random_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/module_teclado_tx.md
Name: module_teclado_tx

Overview:
- Transmit-side counterpart of the keypad capture block.
- Takes a multi-digit BCD number and replays it as a timed sequence of Gray-coded key presses on ag/bg/cg/dg, most significant digit first, with a valid strobe.
- Used as a keypad emulator: drives the capture path from internal logic (self-test, replaying a stored operand) without a physical keypad.

Parameters:
- DIGITS, 3, number of BCD digits per transmitted number (num_in width = 4*DIGITS).
- HOLD_CYCLES, 4, clock cycles each key code is held with key_valid high; legal range >= 1.
- GAP_CYCLES, 2, clock cycles of released key (all-zero code, key_valid low) after each digit; legal range >= 1.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  request to send num_in; sampled only in IDLE.
- num_in  input  4*DIGITS  BCD number; digit DIGITS-1 is the most significant nibble.
- ag  output  1  Gray code bit 3 (MSB).
- bg  output  1  Gray code bit 2.
- cg  output  1  Gray code bit 1.
- dg  output  1  Gray code bit 0 (LSB).
- key_valid  output  1  high while a digit code is being presented.
- busy  output  1  high while a transfer is in progress.
- done  output  1  one-cycle pulse when the last digit's gap completes.

Behaviour:
- All outputs are registered.
- Reset (rst low, asynchronous): state = IDLE; ag/bg/cg/dg = 0, key_valid = 0, busy = 0, done = 0; shift register and counters cleared. Release is synchronous to clk.
- Gray encoding per digit: g = b XOR (b >> 1), giving {ag,bg,cg,dg} = g[3:0].
  - 0 -> 0000, 1 -> 0001, 2 -> 0011, 3 -> 0010, 4 -> 0110
  - 5 -> 0111, 7 -> 0100, 9 -> 1101
- States: IDLE, HOLD, GAP, DONE.
- IDLE:
  - If start = 1 at edge N: latch num_in into a shift register, set digit counter = DIGITS-1, go to HOLD.
  - From edge N+1: busy = 1, key_valid = 1, Gray code of the MS digit driven.
- HOLD:
  - Code held stable for exactly HOLD_CYCLES cycles.
  - Then go to GAP: code = 0000, key_valid = 0.
- GAP:
  - Lasts exactly GAP_CYCLES cycles.
  - If digits remain: shift to the next digit, go to HOLD.
  - Otherwise go to DONE.
- DONE:
  - One cycle: done = 1, busy = 0, key_valid = 0.
  - Next edge: go to IDLE.
- Latency: first key_valid at cycle N+1; done at cycle N+1+DIGITS*(HOLD_CYCLES+GAP_CYCLES). With defaults: done at N+19, busy high for cycles N+1..N+18.
- Start rules:
  - start asserted while busy or in DONE is ignored. It is not queued, and num_in changes after the latch have no effect.
  - start held high continuously: a new transfer begins on the first IDLE cycle, i.e. the cycle after DONE.
- Out-of-range digits (10..15) without the optional feature: encoded with the same formula, no checking.
- Reset mid-transfer: immediate return to the reset values; no done pulse; the partial sequence is abandoned.
- key_valid and the code bits never change in the same cycle as a digit boundary except HOLD->GAP (code to 0000 together with key_valid low) and GAP->HOLD (new code together with key_valid high).

Optional Feature:
- Macro: TECLADO_TX_BCD_CHECK_EN.
- Defined:
  - Adds output err (1 bit, reset 0).
  - At start acceptance, if any nibble of num_in > 9: do not enter HOLD; go directly to DONE.
  - In DONE: done = 1 and err = 1 for that same cycle; no key codes emitted.
  - err is cleared when the next start is accepted.
- Not defined: no err port; every nibble is transmitted as described above.

Test Plan:
- Reset: hold rst low 3 cycles with start = 1 -> all outputs 0, state IDLE; after release with start low, outputs stay 0.
- num_in = 12'h347, start pulse at edge N -> codes 0010 (N+1..N+4), 0000 (N+5..N+6), 0110 (N+7..N+10), 0000, 0100 (N+13..N+16), 0000; done = 1 only at N+19; busy high N+1..N+18.
- num_in = 12'h905, start held high for 40 cycles -> two back-to-back transfers, codes 1101/0000/0111 each time; second key_valid rises at the cycle after the first done.
- Start 12'h111, then start = 1 with num_in = 12'h999 at N+6 -> ignored; sequence remains 0001 x3; exactly one done pulse.
- rst asserted at N+8 during a transfer of 12'h555 -> outputs 0 immediately (asynchronous); no done; a new start after release transmits cleanly from the MS digit.
- With TECLADO_TX_BCD_CHECK_EN: num_in = 12'h3A2 -> key_valid never rises; done and err both high at N+1; a following start with 12'h123 clears err and transmits 0001, 0011, 0010.
